// File: rtl/eighty_twos_mem_responder.sv
// Far-end memory responder for the Eighty_Twos load/store pin protocol: synchronised req,
// programmable access latency, 4-phase req/ack handshake onto a local byte array.
module eighty_twos_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ncs,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              rerr,
  output logic [15:0]       txn_count
);

  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e              state_q, state_d;
  logic                req_s1_q, req_s2_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rerr_q;
  logic [15:0]         txn_count_q;
  logic                capture, enter_ack, complete;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_oor;
  logic [IdxW-1:0]     acc_idx;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    enter_ack = 1'b0;
    complete  = 1'b0;
    if (ncs) begin
      // Abort from any state; nothing uncommitted survives and nothing is counted.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_s2_q) begin
            capture = 1'b1;
            if (LATENCY == 0) begin
              state_d   = StAck;
              enter_ack = 1'b1;
            end else begin
              state_d = StWait;
              cnt_d   = LatCnt;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StAck: begin
          if (!req_s2_q) begin
            state_d  = StIdle;
            complete = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // With zero latency the access happens on the capture edge, so use the live pins.
  always_comb begin
    acc_addr  = capture ? addr  : addr_q;
    acc_we    = capture ? we    : we_q;
    acc_wdata = capture ? wdata : wdata_q;
    acc_oor   = 32'(acc_addr) >= DEPTH;
    acc_idx   = acc_addr[IdxW-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      req_s1_q    <= 1'b0;
      req_s2_q    <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q  <= state_d;
      req_s1_q <= req;
      req_s2_q <= req_s1_q;
      cnt_q    <= cnt_d;
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (enter_ack && !acc_we) begin
        rdata_q <= acc_oor ? '1 : mem_q[acc_idx];
      end
      if (enter_ack) begin
        rerr_q <= acc_oor;
      end else if (state_d != StAck) begin
        rerr_q <= 1'b0;
      end
      if (complete && (txn_count_q != 16'hFFFF)) begin
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_ack && acc_we && !acc_oor) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign ack       = (state_q == StAck);
  assign rdata     = rdata_q;
  assign rerr      = rerr_q;
  assign txn_count = txn_count_q;
  // Live we/ncs gating keeps the pins off the bus the moment the core drives it.
  assign rdata_oe  = (state_q == StAck) & ~we_q & ~we & ~ncs;

endmodule

// File: tb/tb_eighty_twos_mem_responder.sv
// Bench for eighty_twos_mem_responder: three builds (L=2/D=256, L=0/D=256, L=2/D=128)
// driven independently, with a scoreboard of expected handshake results.
module tb_eighty_twos_mem_responder;

  logic        clk;
  logic        n_rst;
  logic        ncs   [3];
  logic        req   [3];
  logic        we    [3];
  logic [7:0]  addr  [3];
  logic [7:0]  wdata [3];
  logic        ack   [3];
  logic [7:0]  rdata [3];
  logic        oe    [3];
  logic        rerr  [3];
  logic [15:0] cnt   [3];

  typedef struct {
    int         d;
    bit         w;
    logic [7:0] rdata;
    bit         rerr;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mm [3][256];
  logic [15:0] cnt_m [3];
  int unsigned lat [3] = '{2, 0, 2};
  int unsigned dep [3] = '{256, 256, 128};
  int          total = 0;
  int          bad   = 0;

  eighty_twos_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .ncs(ncs[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .rdata_oe(oe[0]), .rerr(rerr[0]),
    .txn_count(cnt[0])
  );
  eighty_twos_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(0)) dut1 (
    .clk(clk), .n_rst(n_rst), .ncs(ncs[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .rdata_oe(oe[1]), .rerr(rerr[1]),
    .txn_count(cnt[1])
  );
  eighty_twos_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .LATENCY(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .ncs(ncs[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .rdata_oe(oe[2]), .rerr(rerr[2]),
    .txn_count(cnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full handshake on build d; expectation pushed at drive time, popped at ack.
  task automatic do_txn(input int d, input bit w, input logic [7:0] a, input logic [7:0] wd);
    exp_t e;
    int   n;
    bit   seen;
    bit   oor;
    oor     = (int'(a) >= int'(dep[d]));
    e.d     = d;
    e.w     = w;
    e.rerr  = oor;
    e.rdata = oor ? 8'hFF : mm[d][a];
    if (w && !oor) mm[d][a] = wd;
    sb.push_back(e);
    @(negedge clk);
    we[d] = w; addr[d] = a; wdata[d] = wd; ncs[d] = 1'b0; req[d] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = (ack[d] === 1'b1);
    end
    e = sb.pop_front();
    total++;
    if (!seen || n != 3 + int'(lat[d])) begin
      bad++;
      $display("FAIL ack_latency dut%0d addr=%h: got %0d edges (seen=%0d), need %0d",
               d, a, n, seen, 3 + lat[d]);
    end
    if (seen) begin
      total++;
      if (rerr[d] !== e.rerr) begin
        bad++;
        $display("FAIL rerr dut%0d addr=%h: got %b need %b", d, a, rerr[d], e.rerr);
      end
      total++;
      if (oe[d] !== !e.w) begin
        bad++;
        $display("FAIL rdata_oe dut%0d addr=%h: got %b need %b", d, a, oe[d], !e.w);
      end
      if (!e.w) begin
        total++;
        if (rdata[d] !== e.rdata) begin
          bad++;
          $display("FAIL rdata dut%0d addr=%h: got %h need %h", d, a, rdata[d], e.rdata);
        end
      end
    end
    req[d] = 1'b0;
    n = 0;
    while (ack[d] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ack[d] !== 1'b0) begin
      bad++;
      $display("FAIL ack_release dut%0d: got %b need 0", d, ack[d]);
    end
    if (cnt_m[d] != 16'hFFFF) cnt_m[d] = cnt_m[d] + 16'd1;
    @(negedge clk);
    total++;
    if (cnt[d] !== cnt_m[d]) begin
      bad++;
      $display("FAIL txn_count dut%0d: got %h need %h", d, cnt[d], cnt_m[d]);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ncs[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      cnt_m[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ack[i], oe[i], rerr[i], rdata[i], cnt[i]} !== 27'd0) begin
        bad++;
        $display("FAIL reset dut%0d: ack=%b oe=%b rerr=%b rdata=%h cnt=%h, need all 0",
                 i, ack[i], oe[i], rerr[i], rdata[i], cnt[i]);
      end
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 8'h10, 8'hA5);
    do_txn(0, 1'b0, 8'h10, 8'h00);
    do_txn(0, 1'b1, 8'h00, 8'h3C);
    do_txn(0, 1'b1, 8'hFF, 8'h81);
    do_txn(0, 1'b0, 8'hFF, 8'h00);
    do_txn(0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_zero_latency();
    do_txn(1, 1'b1, 8'h42, 8'h5A);
    do_txn(1, 1'b0, 8'h42, 8'h00);
  endtask

  task automatic test_out_of_range();
    do_txn(2, 1'b1, 8'h10, 8'h22);
    do_txn(2, 1'b1, 8'h7F, 8'h11);
    do_txn(2, 1'b1, 8'h90, 8'hEE);
    do_txn(2, 1'b0, 8'h90, 8'h00);
    do_txn(2, 1'b0, 8'h10, 8'h00);
    do_txn(2, 1'b0, 8'h7F, 8'h00);
  endtask

  task automatic test_abort();
    bit acked;
    do_txn(0, 1'b1, 8'h20, 8'h77);
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 8'h99; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    acked = (ack[0] !== 1'b0);
    ncs[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack[0] !== 1'b0) acked = 1'b1;
    end
    total++;
    if (acked) begin
      bad++;
      $display("FAIL abort_ack: ack seen during aborted write, need none");
    end
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    ncs[0] = 1'b0;
    @(negedge clk);
    total++;
    if (cnt[0] !== cnt_m[0]) begin
      bad++;
      $display("FAIL abort_count: got %h need %h", cnt[0], cnt_m[0]);
    end
    do_txn(0, 1'b0, 8'h20, 8'h00);
  endtask

  task automatic test_contention();
    int n;
    @(negedge clk);
    we[0] = 1'b0; addr[0] = 8'h10; req[0] = 1'b1;
    n = 0;
    while (ack[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ack[0] !== 1'b1 || oe[0] !== 1'b1 || rdata[0] !== 8'hA5) begin
      bad++;
      $display("FAIL contention_read: ack=%b oe=%b rdata=%h, need 1 1 a5",
               ack[0], oe[0], rdata[0]);
    end
    we[0] = 1'b1;
    #1;
    total++;
    if (oe[0] !== 1'b0) begin
      bad++;
      $display("FAIL oe_we_gate: got %b need 0", oe[0]);
    end
    we[0] = 1'b0;
    #1;
    total++;
    if (oe[0] !== 1'b1) begin
      bad++;
      $display("FAIL oe_restore: got %b need 1", oe[0]);
    end
    ncs[0] = 1'b1;
    #1;
    total++;
    if (oe[0] !== 1'b0) begin
      bad++;
      $display("FAIL oe_ncs_gate: got %b need 0", oe[0]);
    end
    @(negedge clk);
    total++;
    if (ack[0] !== 1'b0) begin
      bad++;
      $display("FAIL ncs_ack_drop: got %b need 0", ack[0]);
    end
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    ncs[0] = 1'b0;
    @(negedge clk);
    total++;
    if (cnt[0] !== cnt_m[0]) begin
      bad++;
      $display("FAIL ncs_abort_count: got %h need %h", cnt[0], cnt_m[0]);
    end
  endtask

  task automatic test_saturation();
    int n;
    @(negedge clk);
    force dut0.txn_count_q = 16'hFFFE;
    #1;
    release dut0.txn_count_q;
    cnt_m[0] = 16'hFFFE;
    do_txn(0, 1'b0, 8'h10, 8'h00);
    do_txn(0, 1'b1, 8'h11, 8'h05);
    do_txn(0, 1'b0, 8'h11, 8'h00);
    @(negedge clk);
    we[0] = 1'b0; addr[0] = 8'h10; req[0] = 1'b1;
    n = 0;
    while (ack[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (ack[0] !== 1'b0 || cnt[0] !== 16'd0 || oe[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ack=%b cnt=%h oe=%b, need 0 0000 0", ack[0], cnt[0], oe[0]);
    end
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) cnt_m[i] = '0;
    repeat (2) @(negedge clk);
    do_txn(0, 1'b0, 8'h10, 8'h00);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_latency();
    test_out_of_range();
    test_abort();
    test_contention();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
